// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI mode-0 word transceiver on a start/done handshake; define SPI_LSB_FIRST_EN for LSB-first
module spi_shift_engine #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t            state, state_d;
  logic [DW-1:0]     div_cnt, div_d;
  logic [BW-1:0]     bit_cnt, bit_d;
  logic [DATA_W-1:0] tx_sr, tx_d, rx_sr, rx_d, rxo_d;
  logic              busy_d, done_d, sclk_d, mosi_d;
  logic              div_zero, last, first_bit, next_bit;
  logic [DATA_W-1:0] tx_shift, rx_shift;

  assign div_zero = div_cnt == '0;
  assign last     = bit_cnt == BIT_MAX;

  // tx_sr rotates so every stored bit is consumed; wrapped bits never reach mosi within a word
`ifdef SPI_LSB_FIRST_EN
  assign first_bit = tx_data[0];
  assign tx_shift  = {tx_sr[0], tx_sr[DATA_W-1:1]};
  assign next_bit  = tx_sr[1];
  assign rx_shift  = {miso, rx_sr[DATA_W-1:1]};
`else
  assign first_bit = tx_data[DATA_W-1];
  assign tx_shift  = {tx_sr[DATA_W-2:0], tx_sr[DATA_W-1]};
  assign next_bit  = tx_sr[DATA_W-2];
  assign rx_shift  = {rx_sr[DATA_W-2:0], miso};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      state   <= state_d;
      div_cnt <= div_d;
      bit_cnt <= bit_d;
      tx_sr   <= tx_d;
      rx_sr   <= rx_d;
      rx_data <= rxo_d;
      busy    <= busy_d;
      done    <= done_d;
      sclk    <= sclk_d;
      mosi    <= mosi_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = start ? LOW : IDLE;
      LOW:     state_d = div_zero ? HIGH : LOW;
      HIGH:    state_d = div_zero ? (last ? IDLE : LOW) : HIGH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d  = div_cnt;
    bit_d  = bit_cnt;
    tx_d   = tx_sr;
    rx_d   = rx_sr;
    rxo_d  = rx_data;
    busy_d = busy;
    done_d = 1'b0;
    sclk_d = sclk;
    mosi_d = mosi;
    case (state)
      IDLE: if (start) begin
        tx_d   = tx_data;
        mosi_d = first_bit;
        busy_d = 1'b1;
        div_d  = DIV_MAX;
        bit_d  = '0;
      end
      LOW: if (div_zero) begin
        sclk_d = 1'b1;
        rx_d   = rx_shift;
        div_d  = DIV_MAX;
      end else div_d = div_cnt - 1'b1;
      HIGH: if (div_zero) begin
        sclk_d = 1'b0;
        if (last) begin
          done_d = 1'b1;
          busy_d = 1'b0;
          rxo_d  = rx_sr;
          mosi_d = 1'b0;
        end else begin
          bit_d  = bit_cnt + 1'b1;
          tx_d   = tx_shift;
          mosi_d = next_bit;
          div_d  = DIV_MAX;
        end
      end else div_d = div_cnt - 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: scoreboard bench with an SPI mode-0 slave model for spi_shift_engine
module tb_spi_shift_engine;
  logic       clk = 0, reset = 1, start = 0, miso = 0;
  logic [7:0] tx_data = 0, rx_data;
  logic       busy, done, sclk, mosi;
  logic       start2 = 0, miso2 = 1;
  logic [7:0] tx2 = 0, rx2;
  logic       busy2, done2, sclk2, mosi2;

  always #5 clk = ~clk;

  spi_shift_engine #(.DATA_W(8), .CLK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .rx_data(rx_data),
    .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .miso(miso));

  spi_shift_engine #(.DATA_W(8), .CLK_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .tx_data(tx2), .rx_data(rx2),
    .busy(busy2), .done(done2), .sclk(sclk2), .mosi(mosi2), .miso(miso2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {logic [7:0] tx; logic [7:0] rx; int due;} item_t;
  item_t      sb[$];
  logic [7:0] sq[$];
  int         s_bit = 0, rises = 0;
  logic [7:0] mosi_cap = 0;
  logic       prev_done = 0;

  function automatic logic cur_bit();
    logic [7:0] w;
    if (sq.size() == 0) return 1'b0;
    w = sq[0];
`ifdef SPI_LSB_FIRST_EN
    return w[3'(s_bit)];
`else
    return w[3'(7 - s_bit)];
`endif
  endfunction

  // slave: capture master bits on rise, present next slave bit after each fall
  always @(posedge sclk) if (!reset) begin
`ifdef SPI_LSB_FIRST_EN
    mosi_cap = {mosi, mosi_cap[7:1]};
`else
    mosi_cap = {mosi_cap[6:0], mosi};
`endif
    rises++;
  end

  always @(negedge sclk) if (!reset) begin
    s_bit++;
    if (s_bit == 8) begin
      s_bit = 0;
      if (sq.size() > 0) void'(sq.pop_front());
    end
    miso = cur_bit();
  end

  always @(negedge clk) begin
    item_t it;
    if (!reset && done) begin
      chk("done_busy_overlap", {31'b0, busy}, 0);
      chk("done_width", {31'b0, prev_done}, 0);
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        it = sb.pop_front();
        chk("rx_data", {24'b0, rx_data}, {24'b0, it.rx});
        chk("mosi_bits", {24'b0, mosi_cap}, {24'b0, it.tx});
        chk("sclk_rises", rises, 8);
        chk("done_cycle", cyc, it.due);
      end
      rises = 0;
    end
    prev_done = done;
  end

  task automatic send(input logic [7:0] tx, input logic [7:0] rx, input bit hold);
    int n = 0;
    sq.push_back(rx);
    if (sq.size() == 1) begin
      s_bit = 0;
      miso = cur_bit();
    end
    tx_data = tx;
    start = 1;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      chk("accept_timeout", 1, 0);
      start = 0;
      return;
    end
    sb.push_back('{tx, rx, cyc + 1 + 64});
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_models();
    sb.delete();
    sq.delete();
    s_bit = 0;
    rises = 0;
    miso = 0;
  endtask

  initial begin
    int e, n;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    // single word
    send(8'h9F, 8'hC2, 0);
    wait_drain();
    // start pulse while busy must be ignored
    send(8'h9F, 8'h3C, 0);
    repeat (9) @(negedge clk);
    tx_data = 8'h00;
    start = 1;
    @(negedge clk);
    start = 0;
    tx_data = 8'hFF;
    wait_drain();
    repeat (80) @(negedge clk);
    // asynchronous reset from idle with random inputs
    #1;
    start = 1'($urandom);
    tx_data = 8'($urandom);
    miso = 1'($urandom);
    reset = 1;
    #1;
    chk("rst_rx_data", {24'b0, rx_data}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_sclk", {31'b0, sclk}, 0);
    chk("rst_mosi", {31'b0, mosi}, 0);
    @(negedge clk);
    start = 0;
    clear_models();
    reset = 0;
    @(negedge clk);
    // RDID burst with start held high
    send(8'h9F, 8'h5A, 1);
    send(8'h00, 8'h20, 1);
    send(8'h00, 8'hBA, 1);
    send(8'h00, 8'h18, 0);
    wait_drain();
    // reset mid-transfer while sclk and mosi are high
    send(8'hFF, 8'h77, 0);
    repeat (20) @(negedge clk);
    #1;
    reset = 1;
    #1;
    chk("midrst_sclk", {31'b0, sclk}, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_mosi", {31'b0, mosi}, 0);
    clear_models();
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (80) @(negedge clk);
    send(8'hA5, 8'h96, 0);
    wait_drain();
    // CLK_DIV=2 instance
    tx2 = 8'h9F;
    start2 = 1;
    e = cyc + 1;
    @(negedge clk);
    start2 = 0;
    n = 0;
    while (!done2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("div2_done_cycle", cyc, e + 32);
    chk("div2_rx_data", {24'b0, rx2}, 32'hFF);
    chk("div2_busy", {31'b0, busy2}, 0);
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
